// File: rtl/lights_phase_scheduler.sv
// lights_phase_scheduler: timed two-road phase scheduler with min/max green,
//   yellow and all-red clearance, latched pedestrian walk phase and parade hold on B.
// Latency: Moore outputs, one state register; a timed phase of D cycles exits on
//   the edge where cnt==D-1. There is no backpressure: inputs are sampled every cycle.
// Ports: lights_clk/lights_rstn (async active-low), TA/TB traffic sensors,
//   lights_M parade hold on B, ped_req pedestrian button; LA/LB lamp codes
//   (00 green, 01 yellow, 11 red), ped_walk, phase (state code).
// Build option: define LIGHTS_SCHED_EMERG_EN to add input emerg_a (road-A preemption).
module lights_phase_scheduler #(
  parameter int CNT_W     = 5,
  parameter int MIN_GREEN = 4,
  parameter int MAX_GREEN = 12,
  parameter int YELLOW_T  = 2,
  parameter int ALLRED_T  = 1,
  parameter int WALK_T    = 6
) (
  input  logic       lights_clk,
  input  logic       lights_rstn,
  input  logic       TA,
  input  logic       TB,
  input  logic       lights_M,
  input  logic       ped_req,
`ifdef LIGHTS_SCHED_EMERG_EN
  input  logic       emerg_a,
`endif
  output logic [1:0] LA,
  output logic [1:0] LB,
  output logic       ped_walk,
  output logic [2:0] phase
);

  localparam logic [2:0] AG = 3'd0;
  localparam logic [2:0] AY = 3'd1;
  localparam logic [2:0] AR = 3'd2;
  localparam logic [2:0] BG = 3'd3;
  localparam logic [2:0] BY = 3'd4;
  localparam logic [2:0] BR = 3'd5;
  localparam logic [2:0] PW = 3'd6;

  localparam logic [1:0] GREEN  = 2'b00;
  localparam logic [1:0] YELLOW = 2'b01;
  localparam logic [1:0] RED    = 2'b11;

  // Last count value of each timed interval.
  localparam logic [CNT_W-1:0] MIN_LAST  = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] MAX_LAST  = CNT_W'(MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] YEL_LAST  = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] RED_LAST  = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] WALK_LAST = CNT_W'(WALK_T - 1);

  // dir_next: 1 = B is the next road to get green after a walk phase, 0 = A.
  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             ped_pend;
  logic             dir_next;
  logic             emerg;
  logic             demand_a;
  logic             demand_b;
  logic             state_chg;

`ifdef LIGHTS_SCHED_EMERG_EN
  assign emerg = emerg_a;
`else
  assign emerg = 1'b0;
`endif

  assign demand_b  = TB | lights_M | ped_pend;
  assign demand_a  = TA | ped_pend;
  assign state_chg = (state_nxt != state);

  always_comb begin
    state_nxt = state;
    case (state)
      // Competing traffic on A keeps A green until the max-green timeout.
      AG: if (!emerg && cnt >= MIN_LAST && demand_b && (!TA || cnt == MAX_LAST))
            state_nxt = AY;
      AY: if (cnt == YEL_LAST) state_nxt = AR;
      // Emergency preemption skips the walk phase; the request stays latched.
      AR: if (cnt == RED_LAST) state_nxt = (ped_pend && !emerg) ? PW : BG;
      // Parade mode pins B green; cnt saturates meanwhile, so release is immediate.
      BG: if (emerg ||
              (cnt >= MIN_LAST && !lights_M && demand_a && (!TB || cnt == MAX_LAST)))
            state_nxt = BY;
      BY: if (cnt == YEL_LAST) state_nxt = BR;
      BR: if (cnt == RED_LAST) state_nxt = (ped_pend && !emerg) ? PW : AG;
      PW: if (cnt == WALK_LAST) state_nxt = dir_next ? BG : AG;
      default: state_nxt = AG;  // unused code 7
    endcase
  end

  always_ff @(posedge lights_clk or negedge lights_rstn) begin
    if (!lights_rstn) begin
      state    <= AG;
      cnt      <= '0;
      ped_pend <= 1'b0;
      dir_next <= 1'b1;
    end else begin
      state <= state_nxt;

      if (state_chg)
        cnt <= '0;
      else if (cnt < MAX_LAST)
        cnt <= cnt + 1'b1;

      // Entry to PW clears the latch even if the button is pressed that cycle.
      if (state_chg && state_nxt == PW)
        ped_pend <= 1'b0;
      else if (ped_req && state != PW)
        ped_pend <= 1'b1;

      if (state == AR && state_chg)
        dir_next <= 1'b1;
      else if (state == BR && state_chg)
        dir_next <= 1'b0;
    end
  end

  always_comb begin
    LA       = (state == AG) ? GREEN : (state == AY) ? YELLOW : RED;
    LB       = (state == BG) ? GREEN : (state == BY) ? YELLOW : RED;
    ped_walk = (state == PW);
    phase    = state;
  end

endmodule

// File: tb/tb_lights_phase_scheduler.sv
// Directed bench for lights_phase_scheduler: steps through the reset, sensor,
// max-green, pedestrian, parade and mid-phase reset scenarios with hand-derived
// expected phases, plus a continuous check that both roads are never non-red.
module tb_lights_phase_scheduler;

  logic       lights_clk;
  logic       lights_rstn;
  logic       TA;
  logic       TB;
  logic       lights_M;
  logic       ped_req;
  logic [1:0] LA;
  logic [1:0] LB;
  logic       ped_walk;
  logic [2:0] phase;

  int n_total;
  int n_pass;
  int n_fail;
  int safety_bad;
  bit mon_en;

  lights_phase_scheduler dut (
    .lights_clk  (lights_clk),
    .lights_rstn (lights_rstn),
    .TA          (TA),
    .TB          (TB),
    .lights_M    (lights_M),
    .ped_req     (ped_req),
`ifdef LIGHTS_SCHED_EMERG_EN
    .emerg_a     (1'b0),
`endif
    .LA          (LA),
    .LB          (LB),
    .ped_walk    (ped_walk),
    .phase       (phase)
  );

  initial begin
    lights_clk = 1'b0;
    forever #5 lights_clk = ~lights_clk;
  end

  always @(negedge lights_clk) begin
    if (mon_en) begin
      assert (!(LA != 2'b11 && LB != 2'b11))
      else begin
        safety_bad++;
        $error("FAIL safety: LA=%b LB=%b both non-red", LA, LB);
      end
    end
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [1:0] la, input logic [1:0] lb,
                            input logic [2:0] ph, input logic walk);
    check({tag, ".LA"}, 8'(LA), 8'(la));
    check({tag, ".LB"}, 8'(LB), 8'(lb));
    check({tag, ".phase"}, 8'(phase), 8'(ph));
    check({tag, ".walk"}, 8'(ped_walk), 8'(walk));
  endtask

  task automatic tick();
    @(posedge lights_clk);
    #1;
  endtask

  task automatic do_reset();
    lights_rstn = 1'b0;
    tick();
    tick();
    expect_out("reset", 2'b00, 2'b11, 3'd0, 1'b0);
    lights_rstn = 1'b1;
  endtask

  initial begin
    n_total = 0; n_pass = 0; n_fail = 0; safety_bad = 0; mon_en = 1'b0;
    lights_rstn = 1'b0;
    TA = 1'b1; TB = 1'b0; lights_M = 1'b0; ped_req = 1'b0;

    // Only A traffic: A stays green indefinitely.
    do_reset();
    mon_en = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      check("a_only.phase", 8'(phase), 8'd0);
      check("a_only.LA", 8'(LA), 8'h0);
    end
    expect_out("a_only_end", 2'b00, 2'b11, 3'd0, 1'b0);

    // Only B traffic: AG 4, AY 2, AR 1, then BG.
    TA = 1'b0; TB = 1'b1;
    do_reset();
    check("b_dem.c0", 8'(phase), 8'd0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("b_dem.ag", 8'(phase), 8'd0);
    end
    tick(); expect_out("b_dem.ay1", 2'b01, 2'b11, 3'd1, 1'b0);
    tick(); expect_out("b_dem.ay2", 2'b01, 2'b11, 3'd1, 1'b0);
    tick(); expect_out("b_dem.ar",  2'b11, 2'b11, 3'd2, 1'b0);
    tick(); expect_out("b_dem.bg",  2'b11, 2'b00, 3'd3, 1'b0);

    // Both roads busy: BG lasts MAX_GREEN cycles, then BY, BR, AG; AG likewise.
    TA = 1'b1; TB = 1'b1;
    for (int i = 1; i <= 11; i++) begin
      tick();
      check("max_b.bg", 8'(phase), 8'd3);
    end
    tick(); expect_out("max_b.by", 2'b11, 2'b01, 3'd4, 1'b0);
    tick(); check("max_b.by2", 8'(phase), 8'd4);
    tick(); expect_out("max_b.br", 2'b11, 2'b11, 3'd5, 1'b0);
    tick(); expect_out("max_b.ag", 2'b00, 2'b11, 3'd0, 1'b0);
    for (int i = 1; i <= 11; i++) begin
      tick();
      check("max_a.ag", 8'(phase), 8'd0);
    end
    tick(); expect_out("max_a.ay", 2'b01, 2'b11, 3'd1, 1'b0);

    // Pedestrian pulse in AG cycle 2 with no traffic: walk phase, then BG.
    TA = 1'b0; TB = 1'b0;
    do_reset();
    tick();
    ped_req = 1'b1;
    tick();
    ped_req = 1'b0;
    check("ped.latched", 8'(dut.ped_pend), 8'd1);
    check("ped.ag", 8'(phase), 8'd0);
    tick(); check("ped.ag_last", 8'(phase), 8'd0);
    tick(); check("ped.ay", 8'(phase), 8'd1);
    tick(); check("ped.ay2", 8'(phase), 8'd1);
    tick(); check("ped.ar", 8'(phase), 8'd2);
    tick();
    check("ped.cleared", 8'(dut.ped_pend), 8'd0);
    for (int i = 0; i < 6; i++) begin
      ped_req = (i == 1);
      expect_out("ped.pw", 2'b11, 2'b11, 3'd6, 1'b1);
      tick();
    end
    ped_req = 1'b0;
    expect_out("ped.bg", 2'b11, 2'b00, 3'd3, 1'b0);
    check("ped.ignored_in_pw", 8'(dut.ped_pend), 8'd0);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("ped.no_second_pw", 8'(phase), 8'd3);
    end

    // Parade hold on B well past max green, then release.
    lights_M = 1'b1; TA = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      check("parade.LB", 8'(LB), 8'h0);
    end
    lights_M = 1'b0;
    tick(); expect_out("parade.by", 2'b11, 2'b01, 3'd4, 1'b0);
    tick(); check("parade.by2", 8'(phase), 8'd4);
    tick(); check("parade.br", 8'(phase), 8'd5);
    tick(); expect_out("parade.ag", 2'b00, 2'b11, 3'd0, 1'b0);

    // Reset asserted mid-AY with a pending walk request: immediate return to AG.
    TA = 1'b0; TB = 1'b1;
    for (int i = 1; i <= 3; i++) tick();
    check("rst_mid.ag", 8'(phase), 8'd0);
    tick(); check("rst_mid.ay", 8'(phase), 8'd1);
    ped_req = 1'b1;
    tick();
    ped_req = 1'b0;
    check("rst_mid.ay2", 8'(phase), 8'd1);
    check("rst_mid.pend", 8'(dut.ped_pend), 8'd1);
    #2;
    lights_rstn = 1'b0;
    #1;
    expect_out("rst_mid.async", 2'b00, 2'b11, 3'd0, 1'b0);
    check("rst_mid.pend_clr", 8'(dut.ped_pend), 8'd0);
    TB = 1'b0;
    tick();
    lights_rstn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("rst_mid.idle", 8'(phase), 8'd0);
    end

    check("safety_violations", 8'(safety_bad), 8'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
